// File: rtl/inst_queue_param_if.sv
// Interface bundling the fetch-side push port, issue-side pop port and status of inst_queue_param.
// Optional perf counter signals are present when INSTQ_PERF_CNT_EN is defined.
interface inst_queue_param_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned INST_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // control
    logic              rdy_in;
    logic              flush_from_commit;

    // push side (pc_reg)
    logic              write_from_pc_reg;
    logic [INST_W-1:0] inst_from_pc_reg;
    logic [ADDR_W-1:0] inst_addr_from_pc_reg;
    logic              pred_from_pc_reg;
    logic              full_to_pc_reg;
    logic              almost_full_to_pc_reg;

    // pop side (issue)
    logic              transmit_from_issue;
    logic [INST_W-1:0] inst_to_issue;
    logic [ADDR_W-1:0] inst_addr_to_issue;
    logic              pred_to_issue;
    logic              empty_to_issue;
    logic [CNT_W-1:0]  count_out;

`ifdef INSTQ_PERF_CNT_EN
    logic [31:0]       perf_drop_cnt;
    logic [31:0]       perf_full_cyc;
    logic [31:0]       perf_empty_cyc;

    modport master (
        output rdy_in, flush_from_commit,
        output write_from_pc_reg, inst_from_pc_reg, inst_addr_from_pc_reg, pred_from_pc_reg,
        output transmit_from_issue,
        input  full_to_pc_reg, almost_full_to_pc_reg,
        input  inst_to_issue, inst_addr_to_issue, pred_to_issue, empty_to_issue, count_out,
        input  perf_drop_cnt, perf_full_cyc, perf_empty_cyc
    );

    modport slave (
        input  rdy_in, flush_from_commit,
        input  write_from_pc_reg, inst_from_pc_reg, inst_addr_from_pc_reg, pred_from_pc_reg,
        input  transmit_from_issue,
        output full_to_pc_reg, almost_full_to_pc_reg,
        output inst_to_issue, inst_addr_to_issue, pred_to_issue, empty_to_issue, count_out,
        output perf_drop_cnt, perf_full_cyc, perf_empty_cyc
    );
`else
    modport master (
        output rdy_in, flush_from_commit,
        output write_from_pc_reg, inst_from_pc_reg, inst_addr_from_pc_reg, pred_from_pc_reg,
        output transmit_from_issue,
        input  full_to_pc_reg, almost_full_to_pc_reg,
        input  inst_to_issue, inst_addr_to_issue, pred_to_issue, empty_to_issue, count_out
    );

    modport slave (
        input  rdy_in, flush_from_commit,
        input  write_from_pc_reg, inst_from_pc_reg, inst_addr_from_pc_reg, pred_from_pc_reg,
        input  transmit_from_issue,
        output full_to_pc_reg, almost_full_to_pc_reg,
        output inst_to_issue, inst_addr_to_issue, pred_to_issue, empty_to_issue, count_out
    );
`endif

endinterface

// File: rtl/inst_queue_param.sv
// Parametrised circular instruction queue between fetch (pc_reg) and issue.
// Entries hold {inst, pc, predicted-taken}; the head entry and all flags are registered
// from next-state values so they are exact one cycle after each push/pop.
// Optional feature macro: INSTQ_PERF_CNT_EN adds saturating drop/full/empty perf counters.
module inst_queue_param #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned INST_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned AF_SLACK = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    inst_queue_param_if.slave   q_if
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned AF_LEVEL = DEPTH - AF_SLACK;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic              pred;
    } entry_t;

    entry_t             mem [DEPTH];

    logic [PTR_W-1:0]   head_ptr_q;
    logic [PTR_W-1:0]   tail_ptr_q;
    logic [CNT_W-1:0]   count_q;
    entry_t             head_ent_q;
    logic               full_q;
    logic               af_q;
    logic               empty_q;

    logic               push_ok_c;
    logic               pop_ok_c;
    logic               clear_c;
    logic               advance_c;
    logic [CNT_W-1:0]   count_nxt_c;
    logic [PTR_W-1:0]   head_p1_c;
    entry_t             push_ent_c;
    entry_t             head_nxt_c;

    // Acceptance, next occupancy and next head entry selection
    always_comb begin
        push_ent_c.inst = q_if.inst_from_pc_reg;
        push_ent_c.pc   = q_if.inst_addr_from_pc_reg;
        push_ent_c.pred = q_if.pred_from_pc_reg;

        clear_c     = rst_in || q_if.flush_from_commit;
        push_ok_c   = q_if.write_from_pc_reg && (count_q != CNT_W'(DEPTH));
        pop_ok_c    = q_if.transmit_from_issue && (count_q != '0);
        advance_c   = !clear_c && q_if.rdy_in;
        count_nxt_c = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
        head_p1_c   = head_ptr_q + PTR_W'(1);

        head_nxt_c  = head_ent_q;
        if (count_nxt_c == '0) begin
            head_nxt_c = head_ent_q;
        end else if (push_ok_c && pop_ok_c && (count_q == CNT_W'(1))) begin
            // the only stored entry leaves; the new one goes straight to the head
            head_nxt_c = push_ent_c;
        end else if (push_ok_c && (count_q == '0)) begin
            head_nxt_c = push_ent_c;
        end else if (pop_ok_c) begin
            head_nxt_c = mem[head_p1_c];
        end else begin
            head_nxt_c = mem[head_ptr_q];
        end
    end

    // Storage write; contents are never cleared, validity tracked by pointers
    always_ff @(posedge clk_in) begin
        if (advance_c && push_ok_c) begin
            mem[tail_ptr_q] <= push_ent_c;
        end
    end

    // Pointers, occupancy, flags and registered head entry
    always_ff @(posedge clk_in) begin
        if (clear_c) begin
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
            head_ent_q <= '0;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            empty_q    <= 1'b1;
        end else if (q_if.rdy_in) begin
            head_ptr_q <= head_ptr_q + PTR_W'(pop_ok_c);
            tail_ptr_q <= tail_ptr_q + PTR_W'(push_ok_c);
            count_q    <= count_nxt_c;
            head_ent_q <= head_nxt_c;
            full_q     <= (count_nxt_c == CNT_W'(DEPTH));
            af_q       <= (count_nxt_c >= CNT_W'(AF_LEVEL));
            empty_q    <= (count_nxt_c == '0);
        end
    end

    assign q_if.full_to_pc_reg        = full_q;
    assign q_if.almost_full_to_pc_reg = af_q;
    assign q_if.empty_to_issue        = empty_q;
    assign q_if.count_out             = count_q;
    assign q_if.inst_to_issue         = head_ent_q.inst;
    assign q_if.inst_addr_to_issue    = head_ent_q.pc;
    assign q_if.pred_to_issue         = head_ent_q.pred;

`ifdef INSTQ_PERF_CNT_EN
    logic [31:0] perf_drop_q;
    logic [31:0] perf_full_q;
    logic [31:0] perf_empty_q;
    logic        drop_ev_c;

    // A push refused because the queue is full; pushes lost to flush are not drops
    always_comb begin
        drop_ev_c = q_if.rdy_in && !q_if.flush_from_commit &&
                    q_if.write_from_pc_reg && (count_q == CNT_W'(DEPTH));
    end

    // Saturating perf counters, cleared by reset only so they survive flushes
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_drop_q  <= '0;
            perf_full_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            if (drop_ev_c && (perf_drop_q != 32'hFFFF_FFFF)) begin
                perf_drop_q <= perf_drop_q + 32'd1;
            end
            if (q_if.rdy_in && full_q && (perf_full_q != 32'hFFFF_FFFF)) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
            if (q_if.rdy_in && empty_q && (perf_empty_q != 32'hFFFF_FFFF)) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
        end
    end

    assign q_if.perf_drop_cnt  = perf_drop_q;
    assign q_if.perf_full_cyc  = perf_full_q;
    assign q_if.perf_empty_cyc = perf_empty_q;
`endif

endmodule

// File: tb/tb_inst_queue_param.sv
// Directed self-checking bench for inst_queue_param (DEPTH=8, AF_SLACK=2).
module tb_inst_queue_param;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned AF_SLACK = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    inst_queue_param_if #(.DEPTH(DEPTH), .INST_W(INST_W), .ADDR_W(ADDR_W)) q_if ();

    inst_queue_param #(
        .DEPTH(DEPTH), .INST_W(INST_W), .ADDR_W(ADDR_W), .AF_SLACK(AF_SLACK)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .q_if   (q_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
        q_if.write_from_pc_reg     = 1'b1;
        q_if.inst_from_pc_reg      = inst;
        q_if.inst_addr_from_pc_reg = pc;
        q_if.pred_from_pc_reg      = pred;
        tick();
        q_if.write_from_pc_reg     = 1'b0;
    endtask

    task automatic pop();
        q_if.transmit_from_issue = 1'b1;
        tick();
        q_if.transmit_from_issue = 1'b0;
    endtask

    task automatic check_status(input string tag, input int cnt, input logic empty,
                                input logic full, input logic af);
        check({tag, "_count"}, 32'(q_if.count_out), 32'(cnt));
        check({tag, "_empty"}, 32'(q_if.empty_to_issue), 32'(empty));
        check({tag, "_full"},  32'(q_if.full_to_pc_reg), 32'(full));
        check({tag, "_af"},    32'(q_if.almost_full_to_pc_reg), 32'(af));
    endtask

    initial begin
        rst                        = 1'b1;
        q_if.rdy_in                = 1'b1;
        q_if.flush_from_commit     = 1'b0;
        q_if.write_from_pc_reg     = 1'b0;
        q_if.inst_from_pc_reg      = '0;
        q_if.inst_addr_from_pc_reg = '0;
        q_if.pred_from_pc_reg      = 1'b0;
        q_if.transmit_from_issue   = 1'b0;
        tick();
        tick();

        // reset state
        check_status("rst", 0, 1'b1, 1'b0, 1'b0);
        check("rst_inst", q_if.inst_to_issue, 32'h0);
        check("rst_addr", q_if.inst_addr_to_issue, 32'h0);
        check("rst_pred", 32'(q_if.pred_to_issue), 32'h0);
`ifdef INSTQ_PERF_CNT_EN
        check("rst_perf_drop", q_if.perf_drop_cnt, 32'h0);
        check("rst_perf_full", q_if.perf_full_cyc, 32'h0);
`endif
        rst = 1'b0;

        // push A into empty queue, then pop it
        push(32'hA000_0001, 32'h0, 1'b0);
        check_status("pushA", 1, 1'b0, 1'b0, 1'b0);
        check("pushA_inst", q_if.inst_to_issue, 32'hA000_0001);
        check("pushA_addr", q_if.inst_addr_to_issue, 32'h0);
        pop();
        check_status("popA", 0, 1'b1, 1'b0, 1'b0);
        check("popA_hold", q_if.inst_to_issue, 32'hA000_0001);

        // fill to full; almost_full from count 6, full at 8
        for (int i = 0; i < 8; i++) begin
            push(32'h1000_0000 + 32'(i), 32'(i * 4), 1'b0);
            check_status($sformatf("fill%0d", i), i + 1, 1'b0, 1'b0 || (i == 7),
                         1'b0 || (i >= 5));
            check($sformatf("fill%0d_head", i), q_if.inst_to_issue, 32'h1000_0000);
        end

        // push while full is dropped
        push(32'h1000_0099, 32'h99, 1'b0);
        check_status("drop", 8, 1'b0, 1'b1, 1'b1);
        check("drop_head", q_if.inst_to_issue, 32'h1000_0000);
`ifdef INSTQ_PERF_CNT_EN
        check("drop_perf", q_if.perf_drop_cnt, 32'd1);
`endif

        // full with push+pop: pop accepted, push dropped
        q_if.transmit_from_issue = 1'b1;
        push(32'h0000_0BAD, 32'hBAD, 1'b1);
        q_if.transmit_from_issue = 1'b0;
        check_status("fullpp", 7, 1'b0, 1'b0, 1'b1);
        check("fullpp_head", q_if.inst_to_issue, 32'h1000_0001);
        check("fullpp_addr", q_if.inst_addr_to_issue, 32'h4);
`ifdef INSTQ_PERF_CNT_EN
        check("fullpp_perf", q_if.perf_drop_cnt, 32'd2);
`endif

        // drain in order across the pointer wrap
        for (int j = 1; j <= 7; j++) begin
            pop();
            if (j < 7) begin
                check($sformatf("drain%0d_inst", j), q_if.inst_to_issue,
                      32'h1000_0000 + 32'(j + 1));
                check($sformatf("drain%0d_count", j), 32'(q_if.count_out), 32'(7 - j));
            end else begin
                check_status("drained", 0, 1'b1, 1'b0, 1'b0);
                check("drained_hold", q_if.inst_to_issue, 32'h1000_0007);
            end
        end

        // count=1 with simultaneous push B + pop: bypass
        push(32'h0000_000C, 32'h30, 1'b0);
        check("pushC_inst", q_if.inst_to_issue, 32'h0000_000C);
        q_if.transmit_from_issue = 1'b1;
        push(32'h0000_000B, 32'h34, 1'b0);
        q_if.transmit_from_issue = 1'b0;
        check_status("bypass", 1, 1'b0, 1'b0, 1'b0);
        check("bypass_inst", q_if.inst_to_issue, 32'h0000_000B);
        check("bypass_addr", q_if.inst_addr_to_issue, 32'h34);

        // rdy_in low for 3 cycles with push and pop asserted: nothing moves
        q_if.rdy_in                = 1'b0;
        q_if.write_from_pc_reg     = 1'b1;
        q_if.inst_from_pc_reg      = 32'h0000_000D;
        q_if.transmit_from_issue   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_status($sformatf("hold%0d", k), 1, 1'b0, 1'b0, 1'b0);
            check($sformatf("hold%0d_inst", k), q_if.inst_to_issue, 32'h0000_000B);
        end
        q_if.write_from_pc_reg   = 1'b0;
        q_if.transmit_from_issue = 1'b0;
        q_if.rdy_in              = 1'b1;
        tick();
        check_status("resume", 1, 1'b0, 1'b0, 1'b0);
        check("resume_inst", q_if.inst_to_issue, 32'h0000_000B);

        // build count=5, then flush with a pending push and rdy low
        for (int m = 0; m < 4; m++) begin
            push(32'h2000_0000 + 32'(m), 32'h100 + 32'(m * 4), 1'b1);
        end
        check_status("pre_flush", 5, 1'b0, 1'b0, 1'b0);
        check("pre_flush_inst", q_if.inst_to_issue, 32'h0000_000B);
        q_if.rdy_in            = 1'b0;
        q_if.flush_from_commit = 1'b1;
        push(32'h2000_00FF, 32'h1FC, 1'b1);
        q_if.flush_from_commit = 1'b0;
        q_if.rdy_in            = 1'b1;
        check_status("flush", 0, 1'b1, 1'b0, 1'b0);
        check("flush_inst", q_if.inst_to_issue, 32'h0);
        check("flush_addr", q_if.inst_addr_to_issue, 32'h0);
        check("flush_pred", 32'(q_if.pred_to_issue), 32'h0);
`ifdef INSTQ_PERF_CNT_EN
        check("flush_perf_keep", q_if.perf_drop_cnt, 32'd2);
`endif

        // pop while empty is ignored
        pop();
        check_status("pop_empty", 0, 1'b1, 1'b0, 1'b0);
        check("pop_empty_inst", q_if.inst_to_issue, 32'h0);

        // predicted-taken bit travels with its entry
        push(32'h0000_3001, 32'h3C, 1'b0);
        check("p1_pred", 32'(q_if.pred_to_issue), 32'h0);
        push(32'h0000_3002, 32'h40, 1'b1);
        check("p2_head_pred", 32'(q_if.pred_to_issue), 32'h0);
        check("p2_head_addr", q_if.inst_addr_to_issue, 32'h3C);
        pop();
        check("pred_head", 32'(q_if.pred_to_issue), 32'h1);
        check("pred_addr", q_if.inst_addr_to_issue, 32'h40);
        check("pred_inst", q_if.inst_to_issue, 32'h0000_3002);
        check_status("pred", 1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
